// File: rtl/ela_deinterlacer.sv
// ela_deinterlacer: streams a stored frame from the source memory to the
// processing memory. Even rows (and all rows in COPY mode) are copied one pixel
// per cycle; odd interior rows are rebuilt from their neighbours using
// per-channel edge-based line averaging (ELA) or plain vertical averaging (VLA).
module ela_deinterlacer #(
    parameter int IMG_W      = 400,
    parameter int IMG_H      = 300,
    parameter int CH         = 3,
    parameter int CW         = 4,
    parameter int ADDR_WIDTH = 19,
    parameter int RD_LAT     = 1
) (
    input  logic                  clk_p,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [1:0]            mode,
    output logic                  busy,
    output logic                  done,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [CH*CW-1:0]      rd_data,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [CH*CW-1:0]      wr_data
);
    localparam int PW = CH * CW;
    localparam logic [ADDR_WIDTH-1:0] ONE_A      = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] W_A        = ADDR_WIDTH'(IMG_W);
    localparam logic [ADDR_WIDTH-1:0] LAST_COL   = ADDR_WIDTH'(IMG_W - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ROW   = ADDR_WIDTH'(IMG_H - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_RECON = ADDR_WIDTH'(IMG_H - 2);

    typedef enum logic [2:0] {S_IDLE, S_COPY_ROW, S_FETCH, S_CALC, S_WRITE, S_DONE} state_t;

    state_t                state_q;
    logic [1:0]            mode_q;
    logic                  busy_q, done_q, rd_en_q, wr_en_q, narrow_q;
    logic [ADDR_WIDTH-1:0] rd_addr_q, wr_addr_q;
    logic [PW-1:0]         wr_data_q;
    logic [ADDR_WIDTH-1:0] row_q, row_base_q, col_q, rcol_q;
    logic [2:0]            fidx_q, cap_idx_q;
    logic [RD_LAT-1:0]     vld_q;
    logic [PW-1:0]         cap_q [6];

    logic                  rd_vld;
    logic [ADDR_WIDTH-1:0] row_nx_d, base_nx_d, col_nx_d;
    logic                  narrow_nx_d;
    logic [2:0]            fetch_last;
    logic [PW-1:0]         word [6];
    logic [PW-1:0]         pa, pb, pc, pd, pe, pf;
    logic [PW-1:0]         calc_pix;

    // Read address for neighbour j of pixel c; rows above/below are base-W and base+W.
    // Narrow pixels fetch only b (above) then e (below).
    function automatic logic [ADDR_WIDTH-1:0] fetch_addr(input logic [2:0] j, input logic nar,
                                                         input logic [ADDR_WIDTH-1:0] base,
                                                         input logic [ADDR_WIDTH-1:0] c);
        logic [ADDR_WIDTH-1:0] up, dn;
        up = base - W_A + c;
        dn = base + W_A + c;
        if (nar) return (j == 3'd0) ? up : dn;
        case (j)
            3'd0:    return up - ONE_A;   // a
            3'd1:    return dn + ONE_A;   // f
            3'd2:    return up;           // b
            3'd3:    return dn;           // e
            3'd4:    return up + ONE_A;   // cc
            default: return dn - ONE_A;   // d
        endcase
    endfunction

    // Odd rows that have a row below them are rebuilt in ELA and VLA modes.
    function automatic logic recon_row(input logic [1:0] m, input logic [ADDR_WIDTH-1:0] r);
        return ((m == 2'd1) || (m == 2'd2)) && r[0] && (r <= LAST_RECON);
    endfunction

    assign rd_vld      = vld_q[RD_LAT-1];
    assign row_nx_d    = row_q + ONE_A;
    assign base_nx_d   = row_base_q + W_A;
    assign col_nx_d    = col_q + ONE_A;
    assign narrow_nx_d = (mode_q == 2'd2) || (col_nx_d == LAST_COL);
    assign fetch_last  = narrow_q ? 3'd1 : 3'd5;

    // Neighbour words: the slot being returned this cycle comes straight from rd_data.
    always_comb begin
        for (int j = 0; j < 6; j++) word[j] = (cap_idx_q == 3'(j)) ? rd_data : cap_q[j];
        if (narrow_q) begin
            pa = word[0]; pf = word[1]; pb = word[0]; pe = word[1]; pc = word[0]; pd = word[1];
        end else begin
            pa = word[0]; pf = word[1]; pb = word[2]; pe = word[3]; pc = word[4]; pd = word[5];
        end
    end

    generate
        for (genvar gi = 0; gi < CH; gi++) begin : g_ch
            logic [CW-1:0] a_c, b_c, c_c, d_c, e_c, f_c, d1, d2, d3, out_c;
            logic [CW:0]   s_af, s_be, s_cd;
            assign a_c  = pa[gi*CW +: CW];
            assign b_c  = pb[gi*CW +: CW];
            assign c_c  = pc[gi*CW +: CW];
            assign d_c  = pd[gi*CW +: CW];
            assign e_c  = pe[gi*CW +: CW];
            assign f_c  = pf[gi*CW +: CW];
            assign d1   = (a_c > f_c) ? a_c - f_c : f_c - a_c;
            assign d2   = (b_c > e_c) ? b_c - e_c : e_c - b_c;
            assign d3   = (c_c > d_c) ? c_c - d_c : d_c - c_c;
            assign s_af = {1'b0, a_c} + {1'b0, f_c};
            assign s_be = {1'b0, b_c} + {1'b0, e_c};
            assign s_cd = {1'b0, c_c} + {1'b0, d_c};
            // Pick the direction with the smallest difference; vertical wins ties.
            always_comb begin
                if (narrow_q || ((d2 <= d1) && (d2 <= d3))) out_c = s_be[CW:1];
                else if (d1 <= d3)                          out_c = s_af[CW:1];
                else                                        out_c = s_cd[CW:1];
            end
            assign calc_pix[gi*CW +: CW] = out_c;
        end
    endgenerate

    // Marks the cycle in which the data for an earlier rd_en is on rd_data.
    always_ff @(posedge clk_p) begin
        if (!rst_n) vld_q <= '0;
        else        vld_q <= RD_LAT'({vld_q, rd_en_q});
    end

    // Neighbour capture buffer; contents are only meaningful while a pixel is fetched.
    always_ff @(posedge clk_p) begin
        if (((state_q == S_FETCH) || (state_q == S_CALC)) && rd_vld) cap_q[cap_idx_q] <= rd_data;
    end

    // Frame sequencer: row/column walk, read issue, write generation and handshake.
    always_ff @(posedge clk_p) begin
        if (!rst_n) begin
            state_q <= S_IDLE;   mode_q <= '0;
            busy_q <= 1'b0;      done_q <= 1'b0;
            rd_en_q <= 1'b0;     wr_en_q <= 1'b0;    narrow_q <= 1'b0;
            rd_addr_q <= '0;     wr_addr_q <= '0;    wr_data_q <= '0;
            row_q <= '0;         row_base_q <= '0;   col_q <= '0;    rcol_q <= '0;
            fidx_q <= '0;        cap_idx_q <= '0;
        end else begin
            if (((state_q == S_FETCH) || (state_q == S_CALC)) && rd_vld) cap_idx_q <= cap_idx_q + 3'd1;
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        mode_q <= mode;  busy_q <= 1'b1;
                        row_q <= '0;     row_base_q <= '0;  col_q <= '0;  rcol_q <= '0;
                        rd_en_q <= 1'b1; rd_addr_q <= '0;
                        state_q <= S_COPY_ROW;
                    end
                end
                S_COPY_ROW: begin
                    if (rd_en_q) begin
                        if (rcol_q == LAST_COL) rd_en_q <= 1'b0;
                        else begin
                            rcol_q    <= rcol_q + ONE_A;
                            rd_addr_q <= rd_addr_q + ONE_A;
                        end
                    end
                    wr_en_q <= rd_vld;
                    if (rd_vld) begin
                        wr_data_q <= rd_data;
                        wr_addr_q <= row_base_q + col_q;
                        if (col_q == LAST_COL) state_q <= S_WRITE;  // last write closes the row
                        else                   col_q   <= col_nx_d;
                    end
                end
                S_FETCH: begin
                    if (fidx_q == fetch_last) begin
                        rd_en_q <= 1'b0;
                        state_q <= S_CALC;
                    end else begin
                        fidx_q    <= fidx_q + 3'd1;
                        rd_addr_q <= fetch_addr(fidx_q + 3'd1, narrow_q, row_base_q, col_q);
                    end
                end
                S_CALC: begin
                    if (rd_vld && (cap_idx_q == fetch_last)) begin
                        wr_en_q   <= 1'b1;
                        wr_data_q <= calc_pix;
                        wr_addr_q <= row_base_q + col_q;
                        state_q   <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    wr_en_q <= 1'b0;
                    if (col_q != LAST_COL) begin
                        col_q <= col_nx_d;  narrow_q <= narrow_nx_d;
                        fidx_q <= '0;       cap_idx_q <= '0;
                        rd_en_q <= 1'b1;
                        rd_addr_q <= fetch_addr(3'd0, narrow_nx_d, row_base_q, col_nx_d);
                        state_q <= S_FETCH;
                    end else if (row_q == LAST_ROW) begin
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        row_q <= row_nx_d;  row_base_q <= base_nx_d;
                        col_q <= '0;        rcol_q <= '0;
                        rd_en_q <= 1'b1;
                        if (recon_row(mode_q, row_nx_d)) begin
                            narrow_q <= 1'b1;  fidx_q <= '0;  cap_idx_q <= '0;
                            rd_addr_q <= fetch_addr(3'd0, 1'b1, base_nx_d, '0);
                            state_q <= S_FETCH;
                        end else begin
                            rd_addr_q <= base_nx_d;
                            state_q <= S_COPY_ROW;
                        end
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign rd_en   = rd_en_q;
    assign rd_addr = rd_addr_q;
    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
endmodule

// File: tb/tb_ela_deinterlacer.sv
// Bench for ela_deinterlacer: two instances (4x3 with RD_LAT=1, 5x4 with RD_LAT=3)
// driven from memory models, checked against a per-pixel reference and a
// timing model derived from the read/write latency rules.
module tb_ela_deinterlacer;
    localparam int CH = 3;
    localparam int CW = 4;
    localparam int PW = CH * CW;
    localparam int AW = 19;

    logic clk_p = 1'b0;
    always #5 clk_p = ~clk_p;

    int cyc = 0;
    always @(posedge clk_p) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;
    bit fin [2];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    for (genvar gi = 0; gi < 2; gi++) begin : g_cfg
        localparam int W = (gi == 0) ? 4 : 5;
        localparam int H = (gi == 0) ? 3 : 4;
        localparam int L = (gi == 0) ? 1 : 3;

        logic          rst_n, start, busy, done, rd_en, wr_en;
        logic [1:0]    mode;
        logic [AW-1:0] rd_addr, wr_addr;
        logic [PW-1:0] rd_data, wr_data;

        ela_deinterlacer #(.IMG_W(W), .IMG_H(H), .CH(CH), .CW(CW), .ADDR_WIDTH(AW), .RD_LAT(L)) u_dut (
            .clk_p(clk_p), .rst_n(rst_n), .start(start), .mode(mode), .busy(busy), .done(done),
            .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
            .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data));

        logic [PW-1:0] mem      [W*H];
        logic [PW-1:0] last_out [W*H];
        logic [PW-1:0] rd_pipe  [L];

        always @(posedge clk_p) begin
            rd_pipe[0] <= (rd_en && (int'(rd_addr) < W*H)) ? mem[int'(rd_addr)] : '0;
            for (int i = 1; i < L; i++) rd_pipe[i] <= rd_pipe[i-1];
        end
        assign rd_data = rd_pipe[L-1];

        int            wq_addr [$];
        logic [PW-1:0] wq_data [$];
        int            wq_cyc  [$];
        bit            wq_busy [$];
        int            first_rd, done_cnt, done_cyc, overlap_bad, cur_mode;
        bit            busy_at_done;

        function automatic bit recon(int m, int r);
            return ((m == 1) || (m == 2)) && (r % 2 == 1) && (r <= H - 2);
        endfunction

        function automatic int chv(int addr, int k);
            logic [PW-1:0] v;
            v = mem[addr];
            return int'((v >> (k * CW)) & PW'(15));
        endfunction

        function automatic int iabs(int x);
            return (x < 0) ? -x : x;
        endfunction

        // Reference pixel straight from the averaging rules, integer arithmetic.
        function automatic logic [PW-1:0] exp_pix(int m, int r, int c);
            logic [PW-1:0] res;
            int up, dn, a, b, cc, d, e, f, o;
            res = '0;
            if (!recon(m, r)) return mem[r*W + c];
            up = (r - 1) * W;
            dn = (r + 1) * W;
            for (int k = 0; k < CH; k++) begin
                b = chv(up + c, k);
                e = chv(dn + c, k);
                if ((m == 2) || (c == 0) || (c == W - 1)) o = (b + e) / 2;
                else begin
                    a  = chv(up + c - 1, k);  f = chv(dn + c + 1, k);
                    cc = chv(up + c + 1, k);  d = chv(dn + c - 1, k);
                    if ((iabs(b - e) <= iabs(a - f)) && (iabs(b - e) <= iabs(cc - d))) o = (b + e) / 2;
                    else if (iabs(a - f) <= iabs(cc - d))                               o = (a + f) / 2;
                    else                                                                 o = (cc + d) / 2;
                end
                res[k*CW +: CW] = CW'(o);
            end
            return res;
        endfunction

        always @(negedge clk_p) begin
            if (rd_en && (first_rd < 0)) first_rd = cyc;
            if (wr_en) begin
                wq_addr.push_back(int'(wr_addr));
                wq_data.push_back(wr_data);
                wq_cyc.push_back(cyc);
                wq_busy.push_back(busy);
                if (rd_en && recon(cur_mode, int'(wr_addr) / W)) overlap_bad++;
            end
            if (done) begin
                done_cnt++;
                done_cyc     = cyc;
                busy_at_done = busy;
            end
        end

        task automatic fill_random();
            for (int i = 0; i < W*H; i++) mem[i] = PW'($urandom);
        endtask

        task automatic run_frame(input int m, input bit disturb, input string tag);
            int start_cyc, guard, nw, t_prev, k0, n;
            bit got_done;
            int exp_t [W*H];
            wq_addr.delete(); wq_data.delete(); wq_cyc.delete(); wq_busy.delete();
            first_rd = -1; done_cnt = 0; overlap_bad = 0; cur_mode = m;
            @(negedge clk_p);
            mode = 2'(m); start = 1'b1; start_cyc = cyc;
            @(negedge clk_p);
            start = 1'b0;
            check({tag, "_busy_rise"}, busy, 1);
            got_done = 1'b0; guard = 0;
            while (!got_done && (guard < 3000)) begin
                @(negedge clk_p);
                guard++;
                if (disturb && (guard == 5)) begin start = 1'b1; mode = 2'(3 - m); end
                if (disturb && (guard == 6)) start = 1'b0;
                if (done) got_done = 1'b1;
            end
            check({tag, "_done_seen"}, got_done, 1);
            repeat (8) @(negedge clk_p);
            start = 1'b0; mode = 2'(m);

            // Expected write cycles from the latency rules.
            t_prev = 0;
            for (int r = 0; r < H; r++) begin
                k0 = (r == 0) ? first_rd : t_prev + 1;
                for (int c = 0; c < W; c++) begin
                    if (recon(m, r)) begin
                        n = ((m == 2) || (c == 0) || (c == W - 1)) ? 2 : 6;
                        exp_t[r*W + c] = k0 + n + L;
                        k0 = exp_t[r*W + c] + 1;
                    end else begin
                        exp_t[r*W + c] = k0 + c + L + 1;
                    end
                    t_prev = exp_t[r*W + c];
                end
            end

            nw = wq_addr.size();
            check({tag, "_first_rd"}, first_rd, start_cyc + 1);
            check({tag, "_nwrites"}, nw, W*H);
            for (int i = 0; (i < nw) && (i < W*H); i++) begin
                check($sformatf("%s_addr%0d", tag, i), wq_addr[i], i);
                check($sformatf("%s_data%0d", tag, i), wq_data[i], exp_pix(m, i / W, i % W));
                check($sformatf("%s_wcyc%0d", tag, i), wq_cyc[i], exp_t[i]);
                if ((wq_addr[i] >= 0) && (wq_addr[i] < W*H)) last_out[wq_addr[i]] = wq_data[i];
            end
            check({tag, "_done_cnt"}, done_cnt, 1);
            if (nw > 0) begin
                check({tag, "_done_cyc"}, done_cyc, wq_cyc[nw-1] + 1);
                check({tag, "_busy_last_wr"}, wq_busy[nw-1], 1);
            end
            check({tag, "_busy_at_done"}, busy_at_done, 0);
            check({tag, "_rd_wr_overlap"}, overlap_bad, 0);
            $display("[cfg%0d W=%0d H=%0d L=%0d] %s mode=%0d writes=%0d first_rd=%0d done_cyc=%0d",
                     gi, W, H, L, tag, m, nw, first_rd, done_cyc);
        endtask

        initial begin
            int guard;
            int pat [4];
            int v;
            pat = '{5, 9, 3, 4};
            rst_n = 1'b0; start = 1'b0; mode = 2'd0;
            first_rd = -1; done_cnt = 0; done_cyc = 0; overlap_bad = 0; cur_mode = 0; busy_at_done = 1'b0;
            for (int i = 0; i < W*H; i++) last_out[i] = '0;
            repeat (3) @(negedge clk_p);
            check("rst_busy", busy, 0);       check("rst_done", done, 0);
            check("rst_rd_en", rd_en, 0);     check("rst_wr_en", wr_en, 0);
            check("rst_rd_addr", rd_addr, 0); check("rst_wr_addr", wr_addr, 0);
            check("rst_wr_data", wr_data, 0);
            rst_n = 1'b1;

            for (int i = 0; i < W*H; i++) mem[i] = PW'(i);
            run_frame(0, 1'b0, "copy");

            // Directed ELA pattern: ch0 row0 = 1,2,3..; row2 = 5,9,3,4..; ch1 = 7, ch2 = 15.
            for (int i = 0; i < W*H; i++) begin
                if (i < W)                          v = i + 1;
                else if ((i >= 2*W) && (i < 2*W+4)) v = pat[i - 2*W];
                else if (i >= 2*W)                  v = i - 2*W;
                else                                v = int'($urandom_range(0, 15));
                mem[i] = {4'd15, 4'd7, 4'(v)};
            end
            run_frame(1, 1'b0, "ela_dir");
            check("ela_dir_c0_ch0", last_out[W][3:0], 3);
            check("ela_dir_c1_ch0", last_out[W+1][3:0], 2);
            check("ela_dir_c1_ch1", last_out[W+1][7:4], 7);
            check("ela_dir_c1_ch2", last_out[W+1][11:8], 15);

            fill_random(); run_frame(2, 1'b0, "vla");
            fill_random(); run_frame(1, 1'b0, "ela_rand");
            fill_random(); run_frame(1, 1'b1, "ela_busy_start");
            fill_random(); run_frame(3, 1'b0, "copy3");

            // Abandon a frame with reset while a pixel is being fetched.
            fill_random(); cur_mode = 1;
            @(negedge clk_p); mode = 2'd1; start = 1'b1;
            @(negedge clk_p); start = 1'b0;
            guard = 0;
            while (!(wr_en && (int'(wr_addr) == W)) && (guard < 500)) begin
                @(negedge clk_p);
                guard++;
            end
            check("mid_rst_reach_fetch", guard < 500, 1);
            @(negedge clk_p);
            check("mid_rst_in_fetch", rd_en, 1);
            rst_n = 1'b0;
            @(negedge clk_p);
            rst_n = 1'b1;
            check("mid_rst_busy", busy, 0);       check("mid_rst_done", done, 0);
            check("mid_rst_rd_en", rd_en, 0);     check("mid_rst_wr_en", wr_en, 0);
            check("mid_rst_rd_addr", rd_addr, 0); check("mid_rst_wr_addr", wr_addr, 0);
            check("mid_rst_wr_data", wr_data, 0);
            wq_addr.delete(); wq_data.delete(); wq_cyc.delete(); wq_busy.delete();
            repeat (20) @(negedge clk_p);
            check("mid_rst_no_writes", wq_addr.size(), 0);
            $display("[cfg%0d W=%0d H=%0d L=%0d] mid_fetch_reset writes_after=%0d", gi, W, H, L, wq_addr.size());
            run_frame(1, 1'b0, "ela_after_rst");
            fin[gi] = 1'b1;
        end
    end

    initial begin
        int guard;
        guard = 0;
        while (!(fin[0] && fin[1]) && (guard < 60000)) begin
            @(negedge clk_p);
            guard++;
        end
        if (guard >= 60000) begin
            n_checks++;
            n_errors++;
            $display("FAIL global_timeout: got %0d cycles expected completion", guard);
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/ela_deinterlacer.md
# ela_deinterlacer

Parametrised successor to the single-mode image processor. Reads a stored frame from the source BRAM, rebuilds the odd rows using per-channel edge-based line averaging (ELA), and writes a full frame to the processing memory. Adds a start/done handshake, selectable modes, configurable image size and pixel format, and a configurable BRAM read latency.

## Interface
- IMG_W, 400, pixels per row (≥3)
- IMG_H, 300, rows per frame (≥2)
- CH, 3, colour channels per pixel
- CW, 4, bits per channel
- ADDR_WIDTH, 19, address width (≥ clog2(IMG_W*IMG_H))
- RD_LAT, 1, source-memory read latency in cycles (1..3)

Ports:
- clk_p  in  1  clock; all logic on rising edge
- rst_n  in  1  reset: synchronous, active-low
- start  in  1  one-cycle request to process a frame; sampled only in IDLE
- mode  in  2  0 = COPY, 1 = ELA, 2 = VLA (vertical average only), 3 = COPY; latched on accepted start
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse after the final write
- rd_en  out  1  read strobe to source memory
- rd_addr  out  ADDR_WIDTH  read address
- rd_data  in  CH*CW  read data; valid exactly RD_LAT cycles after its rd_en
- wr_en  out  1  write strobe to processing memory
- wr_addr  out  ADDR_WIDTH  write address
- wr_data  out  CH*CW  write data; channel k is bits [k*CW +: CW]

## Operation
- FSM states: IDLE, COPY_ROW, FETCH, CALC, WRITE, DONE.
- IDLE: on start=1, latch mode and go to COPY_ROW at row 0. start is ignored in every other state.
- Rows are processed in ascending order and every address 0..IMG_W*IMG_H-1 is written exactly once, in ascending order.
- Row r is reconstructed when mode ∈ {1,2}, r is odd, and r ≤ IMG_H-2. Every other row is copied. When IMG_H is even, the last row is copied.
- COPY_ROW streams one read per cycle. Pixel i is written with the unmodified rd_data.
- Reconstruction is done per pixel (r, c). Rows are addressed as A = (r-1)*IMG_W and B = (r+1)*IMG_W.
- FETCH issues six reads on consecutive cycles, in this order:
  - a = A+c-1, f = B+c+1
  - b = A+c, e = B+c
  - cc = A+c+1, d = B+c-1
- In VLA mode, and at edge columns (c = 0 or c = IMG_W-1), FETCH issues only b and e.
- CALC works per channel, each channel independently:
  - d1 = |a-f|, d2 = |b-e|, d3 = |cc-d|
  - if d2 ≤ d1 and d2 ≤ d3: out = (b+e)>>1
  - else if d1 ≤ d3: out = (a+f)>>1
  - else: out = (cc+d)>>1
- In VLA mode and at edge columns: out = (b+e)>>1.
- Sums are CW+1 bits wide and the result is truncated to CW after the shift, so there is never overflow.
- WRITE asserts wr_en for one cycle with wr_addr = r*IMG_W+c, then returns to FETCH for c+1. After the last column it goes to the next row.
- DONE: pulses done for one cycle, then returns to IDLE.

## Timing
- Reset (rst_n=0 at a clock edge): state is IDLE, and busy, done, rd_en, wr_en, rd_addr, wr_addr, wr_data are all 0. This applies mid-frame too: the frame is abandoned and no further writes occur.
- Copy path: wr_en for address i is asserted RD_LAT+1 cycles after rd_en for address i (rd_data is registered into wr_data). Throughput is 1 pixel/cycle.
- Reconstruction, 6-read pixel: reads occupy cycles k..k+5 and wr_en is at cycle k+6+RD_LAT. The next pixel's first read is at cycle k+7+RD_LAT. There is no overlap between pixels.
- Reconstruction, 2-read pixel: reads occupy cycles k, k+1 and wr_en is at cycle k+2+RD_LAT.
- Row transitions: a reconstructed row starts FETCH only after the previous copy row's last write. A copy row starts the cycle after the previous row's last write.
- done is asserted the cycle after the final wr_en. busy falls in the same cycle as done.
- rd_en and wr_en may be high in the same cycle only inside COPY_ROW.

## Test plan
- COPY, IMG_W=4, IMG_H=3, RD_LAT=1, memory[i]=i: 12 writes, addr 0..11, wr_data=i; first wr_en 2 cycles after first rd_en; done one cycle after addr 11.
- ELA, 4×3, channel 0 row0=[1,2,3,4], row2=[5,9,3,4]:
  - row 1 channel 0 = [3,2,...]
  - c=0 is an edge: (1+5)>>1 = 3
  - c=1: d1=2, d2=7, d3=2, so (1+3)>>1 = 2
  - rows 0 and 2 are copied.
- ELA, channel 1 constant 7 and channel 2 = 15 everywhere: reconstructed channel 1 = 7 and channel 2 = 15, showing no overflow and independent per-channel decisions.
- VLA and ELA with IMG_H=4: only row 1 is reconstructed; row 3 is copied; total writes = 16.
- Assert start while busy, and change mode mid-frame: no effect; a single done; the output matches the mode latched at start.
- Drive rst_n=0 mid-FETCH: next cycle all outputs are 0 and no wr_en follows. A new start then produces a complete correct frame. Repeat with RD_LAT=3 and check the latency figures above.
